// File: rtl/touch_pkg.sv
// Shared state encoding and edge-count constants for the touch ADC reader.
// Build macro TOUCH_AVG_EN selects four conversions per axis instead of one.
package touch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] DATA_FIRST = 5'd10;
  localparam logic [4:0] DATA_LAST  = 5'd21;
  localparam logic [4:0] CONV_EDGES = 5'd24;
  localparam int         AVG_SHIFT  = 2;

`ifdef TOUCH_AVG_EN
  localparam logic [3:0] CONV_PER_AXIS = 4'd4;
  localparam logic [3:0] CONV_TOTAL    = 4'd8;
`else
  localparam logic [3:0] CONV_PER_AXIS = 4'd1;
  localparam logic [3:0] CONV_TOTAL    = 4'd2;
`endif

endpackage

// File: rtl/touch_edge_det.sv
// Registers the divider's serial clock and flags its rising and falling edges
// in the clk domain.
module touch_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic dclk,
  output logic rise,
  output logic fall
);

  logic dclk_q;

  always_ff @(posedge clk) begin
    if (rst) dclk_q <= 1'b0;
    else     dclk_q <= dclk;
  end

  assign rise = dclk & ~dclk_q;
  assign fall = ~dclk & dclk_q;

endmodule

// File: rtl/touch_adc_reader.sv
// Serial frame engine for an ADS7843-class touch ADC: one X/Y pair per frame.
// Build macro TOUCH_AVG_EN averages four conversions per axis.
module touch_adc_reader #(
  parameter logic [7:0] CMD_X    = 8'hD0,
  parameter logic [7:0] CMD_Y    = 8'h90,
  parameter int         GAP_CLKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        TP_DCLK,
  input  logic        TP_DOUT,
  input  logic        TP_PENIRQ,
  output logic        DCLK_en,
  output logic        TP_CS,
  output logic        TP_DIN,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        touched,
  output logic        valid,
  output logic        busy
);

  import touch_pkg::*;

  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  logic rise, fall;

  touch_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .dclk (TP_DCLK),
    .rise (rise),
    .fall (fall)
  );

  state_t            state_reg, state_next;
  logic [4:0]        edge_cnt_reg, edge_cnt_next;
  logic [3:0]        conv_cnt_reg, conv_cnt_next;
  logic [7:0]        cmd_reg, cmd_next;
  logic              din_reg, din_next;
  logic              cs_reg, cs_next;
  logic              en_reg, en_next;
  logic [11:0]       data_reg, data_next;
  logic [11:0]       x_tmp_reg, x_tmp_next;
  logic [11:0]       y_tmp_reg, y_tmp_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [11:0]       x_pos_reg, x_pos_next;
  logic [11:0]       y_pos_reg, y_pos_next;
  logic              touched_reg, touched_next;
  logic              valid_reg, valid_next;
  logic [11:0]       sample;
  logic              axis_y, last_of_axis, next_axis_y;
  logic [3:0]        conv_inc;
`ifdef TOUCH_AVG_EN
  logic [13:0]       acc_reg, acc_next, acc_sum;
`endif

  assign conv_inc     = conv_cnt_reg + 4'd1;
  assign axis_y       = (conv_cnt_reg >= CONV_PER_AXIS);
  assign next_axis_y  = (conv_inc >= CONV_PER_AXIS);
  assign last_of_axis = (conv_inc == CONV_PER_AXIS) || (conv_inc == CONV_TOTAL);

  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    conv_cnt_next = conv_cnt_reg;
    cmd_next      = cmd_reg;
    din_next      = din_reg;
    cs_next       = cs_reg;
    en_next       = en_reg;
    data_next     = data_reg;
    x_tmp_next    = x_tmp_reg;
    y_tmp_next    = y_tmp_reg;
    gap_cnt_next  = gap_cnt_reg;
    x_pos_next    = x_pos_reg;
    y_pos_next    = y_pos_reg;
    touched_next  = touched_reg;
    valid_next    = 1'b0;
`ifdef TOUCH_AVG_EN
    acc_next = acc_reg;
    acc_sum  = (((conv_cnt_reg == 4'd0) || (conv_cnt_reg == CONV_PER_AXIS)) ? 14'd0 : acc_reg)
               + {2'b00, data_reg};
    sample   = acc_sum[13:AVG_SHIFT];
`else
    sample   = data_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next    = ST_CONV;
          cs_next       = 1'b0;
          en_next       = 1'b1;
          cmd_next      = CMD_X;
          din_next      = CMD_X[7];
          edge_cnt_next = 5'd0;
          conv_cnt_next = 4'd0;
        end
      end

      ST_CONV: begin
        if (rise) begin
          edge_cnt_next = edge_cnt_reg + 5'd1;
          if (edge_cnt_reg >= DATA_FIRST - 5'd1 && edge_cnt_reg <= DATA_LAST - 5'd1)
            data_next = {data_reg[10:0], TP_DOUT};
          if (edge_cnt_reg == CONV_EDGES - 5'd1) begin
`ifdef TOUCH_AVG_EN
            acc_next = acc_sum;
`endif
            if (last_of_axis) begin
              if (axis_y) y_tmp_next = sample;
              else        x_tmp_next = sample;
            end
            if (conv_inc == CONV_TOTAL) begin
              state_next   = ST_GAP;
              en_next      = 1'b0;
              cs_next      = 1'b1;
              din_next     = 1'b0;
              gap_cnt_next = '0;
            end else begin
              // Next conversion follows directly on the running serial clock.
              conv_cnt_next = conv_inc;
              edge_cnt_next = 5'd0;
              cmd_next      = next_axis_y ? CMD_Y : CMD_X;
              din_next      = next_axis_y ? CMD_Y[7] : CMD_X[7];
            end
          end
        end else if (fall) begin
          // A fall before the first rise of a conversion must not advance the command.
          if (edge_cnt_reg >= 5'd1 && edge_cnt_reg < CMD_BITS) begin
            cmd_next = {cmd_reg[6:0], cmd_reg[7]};
            din_next = cmd_reg[6];
          end else if (edge_cnt_reg >= CMD_BITS) begin
            din_next = 1'b0;
          end
        end
      end

      ST_GAP: begin
        gap_cnt_next = gap_cnt_reg + 1'b1;
        if (gap_cnt_reg == GAP_W'(GAP_CLKS - 1)) begin
          state_next   = ST_IDLE;
          x_pos_next   = x_tmp_reg;
          y_pos_next   = y_tmp_reg;
          touched_next = ~TP_PENIRQ;
          valid_next   = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      edge_cnt_reg <= 5'd0;
      conv_cnt_reg <= 4'd0;
      cmd_reg      <= 8'd0;
      din_reg      <= 1'b0;
      cs_reg       <= 1'b1;
      en_reg       <= 1'b0;
      data_reg     <= 12'd0;
      x_tmp_reg    <= 12'd0;
      y_tmp_reg    <= 12'd0;
      gap_cnt_reg  <= '0;
      x_pos_reg    <= 12'd0;
      y_pos_reg    <= 12'd0;
      touched_reg  <= 1'b0;
      valid_reg    <= 1'b0;
`ifdef TOUCH_AVG_EN
      acc_reg      <= 14'd0;
`endif
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      conv_cnt_reg <= conv_cnt_next;
      cmd_reg      <= cmd_next;
      din_reg      <= din_next;
      cs_reg       <= cs_next;
      en_reg       <= en_next;
      data_reg     <= data_next;
      x_tmp_reg    <= x_tmp_next;
      y_tmp_reg    <= y_tmp_next;
      gap_cnt_reg  <= gap_cnt_next;
      x_pos_reg    <= x_pos_next;
      y_pos_reg    <= y_pos_next;
      touched_reg  <= touched_next;
      valid_reg    <= valid_next;
`ifdef TOUCH_AVG_EN
      acc_reg      <= acc_next;
`endif
    end
  end

  assign DCLK_en = en_reg;
  assign TP_CS   = cs_reg;
  assign TP_DIN  = din_reg;
  assign x_pos   = x_pos_reg;
  assign y_pos   = y_pos_reg;
  assign touched = touched_reg;
  assign valid   = valid_reg;
  assign busy    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_touch_adc_reader.sv
// Randomized bench for touch_adc_reader with a behavioural divider and ADC model.
// Honours TOUCH_AVG_EN to expect four conversions per axis.
module tb_touch_adc_reader;

`ifdef TOUCH_AVG_EN
  localparam int CPA = 4;
`else
  localparam int CPA = 1;
`endif
  localparam int NCONV = 2 * CPA;
  localparam int NRISE = NCONV * 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic TP_DCLK = 1'b0;
  logic TP_DOUT = 1'b0;
  logic TP_PENIRQ = 1'b1;
  logic DCLK_en, TP_CS, TP_DIN, touched, valid, busy;
  logic [11:0] x_pos, y_pos;

  int tests_run = 0;
  int tests_failed = 0;

  bit          hold = 1'b0;
  int          div_cnt = 0;
  int          rises = 0;
  logic [191:0] din_cap = '0;
  logic [11:0] conv_val [8];
  int          valid_cnt = 0;
  logic [11:0] lat_x, lat_y;
  logic        lat_t;
  bit          in_frame = 1'b0;
  int          busy_gap = 0;

  touch_adc_reader dut (
    .clk(clk), .rst(rst), .start(start), .TP_DCLK(TP_DCLK), .TP_DOUT(TP_DOUT),
    .TP_PENIRQ(TP_PENIRQ), .DCLK_en(DCLK_en), .TP_CS(TP_CS), .TP_DIN(TP_DIN),
    .x_pos(x_pos), .y_pos(y_pos), .touched(touched), .valid(valid), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Divider: 8-clk period while enabled, held low when disabled, frozen by hold.
  always @(negedge clk) begin
    if (DCLK_en !== 1'b1) begin
      div_cnt = 0;
      TP_DCLK = 1'b0;
    end else if (!hold) begin
      if (div_cnt == 3) begin
        div_cnt = 0;
        TP_DCLK = ~TP_DCLK;
      end else begin
        div_cnt++;
      end
    end
  end

  // ADC model: counts rises in the frame, records DIN, shifts results out on falls.
  always @(negedge TP_CS) begin
    rises = 0;
    din_cap = '0;
  end

  always @(posedge TP_DCLK) begin
    if (TP_CS === 1'b0) begin
      rises++;
      if (rises <= 192) din_cap[rises-1] = TP_DIN;
    end
  end

  always @(negedge TP_DCLK) begin
    int n, c, pos;
    if (TP_CS === 1'b0) begin
      n   = rises + 1;
      c   = (n - 1) / 24;
      pos = (n - 1) % 24 + 1;
      if (pos >= 10 && pos <= 21 && c < 8) TP_DOUT = conv_val[c][21-pos];
      else                                 TP_DOUT = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (in_frame && busy !== 1'b1 && valid !== 1'b1) busy_gap++;
    if (valid === 1'b1) begin
      valid_cnt++;
      lat_x = x_pos;
      lat_y = y_pos;
      lat_t = touched;
      in_frame = 1'b0;
    end
  end

  function automatic logic [191:0] exp_din();
    logic [191:0] f;
    logic [7:0]   cmd;
    f = '0;
    for (int c = 0; c < NCONV; c++) begin
      cmd = (c < CPA) ? 8'hD0 : 8'h90;
      for (int p = 0; p < 8; p++) f[c*24+p] = cmd[7-p];
    end
    return f;
  endfunction

  function automatic logic [11:0] exp_axis(input int base);
    int sum;
    sum = 0;
    for (int i = 0; i < CPA; i++) sum += int'(conv_val[base+i]);
    return 12'(sum / CPA);
  endfunction

  task automatic set_vals(input logic [11:0] xv, input logic [11:0] yv, input bit rnd);
    for (int i = 0; i < 8; i++) begin
      if (rnd) conv_val[i] = 12'($urandom_range(0, 4095));
      else     conv_val[i] = (i < CPA) ? xv : yv;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_rises(input int n, output bit to);
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (rises >= n && TP_CS === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int v0, output bit to);
    to = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (valid_cnt != v0) begin to = 1'b0; break; end
    end
  endtask

  task automatic drive_frame(input logic pen, output bit to);
    int v0;
    TP_PENIRQ = pen;
    v0 = valid_cnt;
    busy_gap = 0;
    pulse_start();
    in_frame = 1'b1;
    wait_valid(v0, to);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({TP_CS, DCLK_en, TP_DIN, touched, valid, busy, x_pos, y_pos} !== {1'b1, 5'b0, 24'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got cs=%b en=%b din=%b t=%b v=%b b=%b x=%h y=%h, want cs=1 rest 0",
               TP_CS, DCLK_en, TP_DIN, touched, valid, busy, x_pos, y_pos);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset: outputs cs=%b busy=%b x=%h y=%h", TP_CS, busy, x_pos, y_pos);
  endtask

  task automatic test_basic();
    bit to; int v0;
    set_vals(12'hA5C, 12'h3F1, 1'b0);
    v0 = valid_cnt;
    drive_frame(1'b1, to);
    tests_run++;
    if (to) begin tests_failed++; $display("FAIL basic_timeout: no valid within budget"); end
    tests_run++;
    if ({lat_x, lat_y} !== {exp_axis(0), exp_axis(CPA)}) begin
      tests_failed++;
      $display("FAIL basic_xy: got %h/%h want %h/%h", lat_x, lat_y, exp_axis(0), exp_axis(CPA));
    end
    tests_run++;
    if (rises != NRISE) begin tests_failed++; $display("FAIL basic_rises: got %0d want %0d", rises, NRISE); end
    tests_run++;
    if (din_cap !== exp_din()) begin tests_failed++; $display("FAIL basic_din: got %h want %h", din_cap, exp_din()); end
    repeat (20) @(negedge clk);
    tests_run++;
    if (valid_cnt - v0 != 1 || busy_gap != 0) begin
      tests_failed++;
      $display("FAIL basic_valid_busy: pulses %0d want 1, busy gaps %0d want 0", valid_cnt - v0, busy_gap);
    end
    $display("[TB] basic frame: x=%h y=%h rises=%0d", lat_x, lat_y, rises);
  endtask

  task automatic test_touch();
    bit to;
    for (int k = 0; k < 2; k++) begin
      set_vals(12'h0, 12'h0, 1'b1);
      drive_frame(k[0], to);
      tests_run++;
      if (to || lat_t !== ~k[0] || lat_x !== exp_axis(0) || lat_y !== exp_axis(CPA)) begin
        tests_failed++;
        $display("FAIL touch_%0d: to=%b got t=%b x=%h y=%h want t=%b x=%h y=%h", k, to, lat_t,
                 lat_x, lat_y, ~k[0], exp_axis(0), exp_axis(CPA));
      end
      $display("[TB] touch frame pen=%0d: touched=%b x=%h y=%h", k, lat_t, lat_x, lat_y);
    end
  endtask

  task automatic test_restart_ignored();
    bit to; int v0;
    set_vals(12'h0, 12'h0, 1'b1);
    TP_PENIRQ = 1'b0;
    v0 = valid_cnt;
    busy_gap = 0;
    pulse_start();
    in_frame = 1'b1;
    wait_rises(5, to);
    pulse_start();
    wait_rises(30, to);
    pulse_start();
    wait_valid(v0, to);
    repeat (300) @(negedge clk);
    tests_run++;
    if (to || valid_cnt - v0 != 1 || busy_gap != 0 || busy !== 1'b0 || TP_CS !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_ignored: to=%b pulses=%0d want 1, busy gaps=%0d want 0, busy=%b cs=%b",
               to, valid_cnt - v0, busy_gap, busy, TP_CS);
    end
    tests_run++;
    if (lat_x !== exp_axis(0) || lat_y !== exp_axis(CPA) || rises != NRISE) begin
      tests_failed++;
      $display("FAIL restart_data: got %h/%h rises %0d want %h/%h rises %0d", lat_x, lat_y, rises,
               exp_axis(0), exp_axis(CPA), NRISE);
    end
    $display("[TB] restart ignored: pulses=%0d x=%h y=%h", valid_cnt - v0, lat_x, lat_y);
  endtask

  task automatic test_reset_mid();
    bit to; int v0;
    set_vals(12'h0, 12'h0, 1'b1);
    v0 = valid_cnt;
    pulse_start();
    wait_rises(15, to);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (to || {TP_CS, DCLK_en, busy, valid, x_pos, y_pos} !== {1'b1, 3'b0, 24'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: to=%b got cs=%b en=%b busy=%b v=%b x=%h y=%h want cs=1 rest 0",
               to, TP_CS, DCLK_en, busy, valid, x_pos, y_pos);
    end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    tests_run++;
    if (valid_cnt != v0) begin tests_failed++; $display("FAIL reset_mid_valid: pulses %0d want 0", valid_cnt - v0); end
    set_vals(12'hA5C, 12'h3F1, 1'b0);
    drive_frame(1'b1, to);
    tests_run++;
    if (to || lat_x !== 12'hA5C || lat_y !== 12'h3F1) begin
      tests_failed++;
      $display("FAIL reset_mid_recover: to=%b got %h/%h want a5c/3f1", to, lat_x, lat_y);
    end
    $display("[TB] reset mid-frame then frame: x=%h y=%h", lat_x, lat_y);
  endtask

  task automatic test_avg();
    bit to;
    set_vals(12'h0, 12'h0, 1'b1);
    for (int i = 0; i < CPA; i++) conv_val[i] = 12'(100 + i);
    drive_frame(1'b1, to);
    tests_run++;
    if (to || lat_x !== exp_axis(0) || lat_y !== exp_axis(CPA) || rises != NRISE) begin
      tests_failed++;
      $display("FAIL avg: to=%b got %0d/%h rises %0d want %0d/%h rises %0d", to, lat_x, lat_y, rises,
               exp_axis(0), exp_axis(CPA), NRISE);
    end
    $display("[TB] avg frame: x=%0d y=%h rises=%0d", lat_x, lat_y, rises);
  endtask

  task automatic test_stall();
    bit to; int v0, r0;
    set_vals(12'h0, 12'h0, 1'b1);
    v0 = valid_cnt;
    busy_gap = 0;
    pulse_start();
    in_frame = 1'b1;
    wait_rises(20, to);
    hold = 1'b1;
    r0 = rises;
    repeat (1000) @(negedge clk);
    tests_run++;
    if (to || rises != r0 || busy !== 1'b1 || TP_CS !== 1'b0 || valid_cnt != v0) begin
      tests_failed++;
      $display("FAIL stall_hold: to=%b rises %0d want %0d, busy=%b cs=%b pulses=%0d", to, rises, r0,
               busy, TP_CS, valid_cnt - v0);
    end
    hold = 1'b0;
    wait_valid(v0, to);
    tests_run++;
    if (to || lat_x !== exp_axis(0) || lat_y !== exp_axis(CPA) || rises != NRISE || din_cap !== exp_din()) begin
      tests_failed++;
      $display("FAIL stall_resume: to=%b got %h/%h rises %0d want %h/%h rises %0d", to, lat_x, lat_y,
               rises, exp_axis(0), exp_axis(CPA), NRISE);
    end
    $display("[TB] stall frame: x=%h y=%h", lat_x, lat_y);
  endtask

  task automatic test_back_to_back();
    bit to; logic pen;
    for (int k = 0; k < 5; k++) begin
      set_vals(12'h0, 12'h0, 1'b1);
      pen = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      drive_frame(pen, to);
      tests_run++;
      if (to || lat_t !== ~pen || lat_x !== exp_axis(0) || lat_y !== exp_axis(CPA) ||
          din_cap !== exp_din() || busy_gap != 0) begin
        tests_failed++;
        $display("FAIL random_%0d: to=%b got t=%b x=%h y=%h gaps=%0d want t=%b x=%h y=%h", k, to,
                 lat_t, lat_x, lat_y, busy_gap, ~pen, exp_axis(0), exp_axis(CPA));
      end
      $display("[TB] random frame %0d: touched=%b x=%h y=%h", k, lat_t, lat_x, lat_y);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) conv_val[i] = 12'h0;
    test_reset();
    test_basic();
    test_touch();
    test_restart_ignored();
    test_reset_mid();
    test_avg();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
